multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control unit that drives the register-file/ALU/data-RAM datapath. It fetches 32-bit RV32I instructions over a request/valid handshake and decodes them. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, producing the datapath's register addresses, immediate and control strobes, and maintaining the PC. It consumes the datapath's `eq` flag to resolve branches.

## Interface
- `Address_Width_RegFile`, default 5: register address width.
- `Data_Width`, default 32: instruction, immediate and PC width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction word; sampled only in FETCH when `instr_valid`=1.
- `instr_valid` in 1: instruction word is valid this cycle.
- `instr_req` out 1: instruction fetch request for the word at `pc`.
- `pc` out Data_Width: current instruction address.
- `eq` in 1: datapath flag, 1 when rd1 == ALUOp2.
- `rs1`, `rs2`, `rd` out Address_Width_RegFile: register addresses.
- `regFileWen` out 1: register write enable.
- `ALUSrc` out 1: ALU operand-2 select; 1 selects `ImmOp`.
- `ImmOp` out Data_Width: sign-extended immediate.
- `ALU_ctrl` out 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT.
- `MemWrite` out 1: data-RAM write enable.
- `ResultSrc` out 1: writeback source; 0 = ALU, 1 = RAM read data.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.

## Operation
- **Supported instructions:**
  - R-type (0110011): add, sub, and, or, slt.
  - addi (0010011, f3=000).
  - lw (0000011, f3=010).
  - sw (0100011, f3=010).
  - beq (1100011, f3=000).
  - bne (f3=001; see Configuration).
- **FETCH:** `instr_req`=1. Stay in FETCH until `instr_valid`=1, then latch `instr` and go to DECODE.
- **DECODE (1 cycle):**
  - Register `rs1`=instr[19:15], `rs2`=instr[24:20], `rd`=instr[11:7].
  - Register `ImmOp`:
    - I-type: sext(instr[31:20]).
    - S-type: sext({instr[31:25], instr[11:7]}).
    - B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Unsupported opcode/funct: pulse `illegal`, set pc <= pc+4, go to FETCH.
- **EXECUTE (1 cycle):**
  - Drive `ALU_ctrl` and `ALUSrc`: R-type ALUSrc=0; addi/lw/sw ALUSrc=1 with ADD.
  - Branches: SUB with ALUSrc=0. Sample `eq` at the end of the cycle.
  - Taken branch: pc <= pc+ImmOp. Not taken: pc <= pc+4. Then go to FETCH.
  - R/addi go to WB; lw/sw go to MEM.
- **MEM (1 cycle):**
  - sw: `MemWrite`=1 for exactly this cycle, pc <= pc+4, go to FETCH.
  - lw: read cycle, go to WB.
- **WB (1 cycle):**
  - `regFileWen`=1, except forced to 0 when rd==0.
  - `ResultSrc`=1 for lw, 0 otherwise.
  - pc <= pc+4, go to FETCH.
- **Stable operands:** `rs1`, `rs2`, `ImmOp`, `ALUSrc` and `ALU_ctrl` hold their values from EXECUTE through the end of WB, so the ALU result stays valid at writeback.
- **Arithmetic:** PC arithmetic is modulo 2^Data_Width and wraps silently.

## Timing
- **Reset:** while `rst_n`=0:
  - State = FETCH; pc = RESET_PC.
  - All other outputs are 0, including `instr_req`.
  - `instr_valid` is ignored.
- **After reset:** `instr_req`=1 in the first cycle after `rst_n` deasserts.
- **Reset mid-instruction:** the instruction is abandoned with no partial `MemWrite` or `regFileWen` pulse afterwards. The PC returns to RESET_PC.
- **Cycles per instruction, with zero fetch wait:**
  - R/addi: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne: 3.
  - illegal: 2.
- Each fetch wait cycle adds 1.
- **Output style:** strobes (`MemWrite`, `regFileWen`, `illegal`, `instr_req`) are Moore outputs decoded from state. They never assert outside their state.
- **`instr_valid` outside FETCH:** ignored, with no effect on any state.
- **`eq`:** has effect only in EXECUTE of a branch.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN`:
  - **Defined:** bne is supported; the branch is taken when `eq`=0.
  - **Undefined:** f3=001 on opcode 1100011 decodes as illegal, pulsing `illegal` and advancing pc by 4.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXECUTE, release. Required: pc=RESET_PC, `instr_req`=1 on the first cycle, no `regFileWen`/`MemWrite` pulse.
- **addi:** `instr`=0x00500093 (addi x1,x0,5), valid after a 2-cycle wait. Required: `ImmOp`=5, ALUSrc=1, ALU_ctrl=0000, rd=1, `regFileWen` for 1 cycle, pc 0→4, 6 cycles total.
- **R-type add:** `instr`=0x002081B3 (add x3,x1,x2). Required: rs1=1, rs2=2, rd=3, ALUSrc=0, ALU_ctrl=0000, ResultSrc=0 in WB.
- **Store:** `instr`=0x00102423 (sw x1,8(x0)). Required: ImmOp=8, `MemWrite`=1 for exactly 1 cycle, `regFileWen` never asserted.
- **Load:** `instr`=0x00802283 (lw x5,8(x0)). Required: `MemWrite`=0 throughout, WB with ResultSrc=1 and rd=5, 5 cycles.
- **Branch:** at pc=0x20, `instr`=0xFE208CE3 (beq x1,x2,-8).
  - eq=1: pc becomes 0x18.
  - eq=0: pc becomes 0x24.
  - With the macro undefined, f3=001 produces an `illegal` pulse and pc becomes 0x24.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I-subset multicycle control FSM (FETCH/DECODE/EXECUTE/MEM/WB) with PC.
// Define MULTICYCLE_CTRL_BNE_EN to support bne; otherwise bne decodes as illegal.
module multicycle_ctrl #(
    parameter int                    Address_Width_RegFile = 5,
    parameter int                    Data_Width            = 32,
    parameter logic [Data_Width-1:0] RESET_PC              = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [31:0]                      instr,
    input  logic                             instr_valid,
    output logic                             instr_req,
    output logic [Data_Width-1:0]            pc,
    input  logic                             eq,
    output logic [Address_Width_RegFile-1:0] rs1,
    output logic [Address_Width_RegFile-1:0] rs2,
    output logic [Address_Width_RegFile-1:0] rd,
    output logic                             regFileWen,
    output logic                             ALUSrc,
    output logic [Data_Width-1:0]            ImmOp,
    output logic [3:0]                       ALU_ctrl,
    output logic                             MemWrite,
    output logic                             ResultSrc,
    output logic                             illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;
    typedef enum logic [2:0] {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_t;

    state_t                state, next;
    kind_t                 kind, dec_kind;
    logic [31:0]           ir;
    logic [3:0]            dec_alu;
    logic [Data_Width-1:0] dec_imm, imm_i, imm_s, imm_b;
    logic [6:0]            op, f7;
    logic [2:0]            f3;
    logic                  is_br, taken, pc_step, pc_jump;

    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];
    assign imm_i = {{(Data_Width-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(Data_Width-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(Data_Width-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign dec_imm = op == 7'b0100011 ? imm_s : op == 7'b1100011 ? imm_b : imm_i;

    always_comb begin
        dec_kind = K_ILL;
        dec_alu = 4'b0000;
        case (op)
            7'b0110011: begin
                dec_kind = K_R;
                if (f7 == 7'b0100000 && f3 == 3'b000) dec_alu = 4'b0001;
                else if (f7 != 7'b0000000) dec_kind = K_ILL;
                else if (f3 == 3'b111) dec_alu = 4'b0010;
                else if (f3 == 3'b110) dec_alu = 4'b0011;
                else if (f3 == 3'b010) dec_alu = 4'b0101;
                else if (f3 != 3'b000) dec_kind = K_ILL;
            end
            7'b0010011: dec_kind = f3 == 3'b000 ? K_ADDI : K_ILL;
            7'b0000011: dec_kind = f3 == 3'b010 ? K_LW : K_ILL;
            7'b0100011: dec_kind = f3 == 3'b010 ? K_SW : K_ILL;
            7'b1100011: begin
                dec_alu = 4'b0001;
`ifdef MULTICYCLE_CTRL_BNE_EN
                dec_kind = f3 == 3'b000 ? K_BEQ : f3 == 3'b001 ? K_BNE : K_ILL;
`else
                dec_kind = f3 == 3'b000 ? K_BEQ : K_ILL;
`endif
            end
            default: dec_kind = K_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            FETCH:   next = instr_valid ? DECODE : FETCH;
            DECODE:  next = dec_kind == K_ILL ? FETCH : EXECUTE;
            EXECUTE: next = is_br ? FETCH : (kind == K_LW || kind == K_SW) ? MEM : WB;
            MEM:     next = kind == K_SW ? FETCH : WB;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        instr_req = rst_n && state == FETCH;
        illegal = state == DECODE && dec_kind == K_ILL;
        MemWrite = state == MEM && kind == K_SW;
        regFileWen = state == WB && rd != '0;
        ResultSrc = state == WB && kind == K_LW;
    end

    assign is_br = kind == K_BEQ || kind == K_BNE;
    assign taken = kind == K_BNE ? !eq : eq;
    assign pc_jump = state == EXECUTE && is_br && taken;
    assign pc_step = (state == DECODE && dec_kind == K_ILL) || (state == EXECUTE && is_br && !taken)
                   || (state == MEM && kind == K_SW) || state == WB;

    // Operands are latched in DECODE and held until the next DECODE, keeping the ALU result stable through WB.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc <= RESET_PC;
            ir <= '0;
            kind <= K_R;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            ImmOp <= '0;
            ALU_ctrl <= '0;
            ALUSrc <= 1'b0;
        end else begin
            if (state == FETCH && instr_valid) ir <= instr;
            if (state == DECODE) begin
                rs1 <= Address_Width_RegFile'(ir[19:15]);
                rs2 <= Address_Width_RegFile'(ir[24:20]);
                rd <= Address_Width_RegFile'(ir[11:7]);
                ImmOp <= dec_imm;
                ALU_ctrl <= dec_alu;
                ALUSrc <= dec_kind == K_ADDI || dec_kind == K_LW || dec_kind == K_SW;
                kind <= dec_kind;
            end
            if (pc_jump) pc <= pc + ImmOp;
            else if (pc_step) pc <= pc + Data_Width'(4);
        end
endmodule
